// File: rtl/spi_slave_sync.sv
// ============================================================================
//  Module      : spi_slave_sync
//  Description : SPI slave with all pins oversampled in the sys_clk domain.
//                Supports CPOL/CPHA modes 0-3, one DATA_WIDTH-bit word per
//                frame (back-to-back words while cs stays low), a single-entry
//                TX holding register with load handshake, an RX valid pulse
//                and a frame-error pulse on mid-word deselect.
//                Optional build macro SPI_SLAVE_ECHO_EN: on TX underrun the
//                last received word is shifted out instead of zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_sync #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int              CNT_W      = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    // Synchronizer chains: [0],[1] are the 2-flop synchronizer, [2] is the
    // previous synchronized value used for edge detection.
    logic [2:0]            r_cs_sync;
    logic [2:0]            r_sclk_sync;
    logic [1:0]            r_mosi_sync;

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_tx_hold;
    logic                  r_tx_ready;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;

    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_drive;
    logic                  w_word_done;
    logic                  w_word_start;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] w_underrun_word;
    logic [DATA_WIDTH-1:0] w_next_tx;

    assign w_cs_fall   = ~r_cs_sync[1] &  r_cs_sync[2];
    assign w_cs_rise   =  r_cs_sync[1] & ~r_cs_sync[2];
    assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];

    // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
    assign w_lead   = cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample = cpha ? w_trail : w_lead;
    assign w_drive  = cpha ? w_lead  : w_trail;

    assign w_rx_next = {r_rx_shift, r_mosi_sync[1]};

    // A deselect takes priority over a coincident final sample edge.
    assign w_word_done  = (r_state == c_ACTIVE) && !w_cs_rise && w_sample
                          && (r_bit_cnt == c_LAST_BIT);
    assign w_word_start = ((r_state == c_IDLE) && w_cs_fall) || w_word_done;

`ifdef SPI_SLAVE_ECHO_EN
    assign w_underrun_word = r_rx_data;
`else
    assign w_underrun_word = '0;
`endif

    // An empty holding register (tx_ready high) means underrun.
    assign w_next_tx = r_tx_ready ? w_underrun_word : r_tx_hold;

    assign miso      = (r_state == c_ACTIVE) & r_tx_shift[DATA_WIDTH-1];
    assign busy      = (r_state == c_ACTIVE);
    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

    // Bring the asynchronous SPI pins into the sys_clk domain.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0], cs};
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    // Frame state machine with bit counter and RX/TX shift registers.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= c_ACTIVE;
                        r_bit_cnt  <= '0;
                        r_tx_shift <= w_next_tx;
                    end
                end
                c_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state   <= c_IDLE;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sample) begin
                        r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_tx_shift <= w_next_tx;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_drive && (r_bit_cnt != '0)) begin
                        // No shift at word start keeps the MSB on miso for
                        // the first CPHA=1 leading edge.
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // TX holding register: word start drains it, a load is refused that cycle.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_hold  <= '0;
            r_tx_ready <= 1'b1;
        end else if (w_word_start) begin
            r_tx_ready <= 1'b1;
        end else if (tx_load && r_tx_ready) begin
            r_tx_hold  <= tx_data;
            r_tx_ready <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
// ============================================================================
//  Module      : tb_spi_slave_sync
//  Description : Self-checking bench for spi_slave_sync. A bench-side SPI
//                master drives frames; received words are predicted into a
//                scoreboard queue and compared on every rx_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_sync;

    localparam int W  = 32;
    localparam int HP = 6;   // sclk half period in sys_clk cycles

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [31:0] tx_word;
        logic [31:0] mosi_word;
        logic [31:0] exp_rx;
        logic [31:0] exp_miso;
    } vec_t;

    logic         sys_clk = 1'b0;
    logic         rstn    = 1'b0;
    logic         cpol    = 1'b0;
    logic         cpha    = 1'b0;
    logic         cs      = 1'b1;
    logic         sclk    = 1'b0;
    logic         mosi    = 1'b0;
    logic         tx_load = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         frame_err;
    logic         busy;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_valid  = 0;
    int           n_ferr   = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] last_rx  = '0;

    always #5 sys_clk = ~sys_clk;

    spi_slave_sync #(.DATA_WIDTH(W)) u_dut (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .cpol      (cpol),
        .cpha      (cpha),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every rx_valid pulse must match the oldest prediction.
    always @(negedge sys_clk) begin : mon
        logic [W-1:0] e;
        if (rx_valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got rx_valid with 0x%08h, expected no pulse", rx_data);
            end else begin
                e = sb.pop_front();
                check("rx_data_sb", rx_data, e);
            end
        end
        if (frame_err === 1'b1) n_ferr++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic halfp();
        idle_cycles(HP);
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        idle_cycles(8);
    endtask

    task automatic load(input logic [31:0] w);
        @(negedge sys_clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge sys_clk);
        tx_load = 1'b0;
    endtask

    // Shift the low nbits of mo out MSB first; collect miso into mi.
    task automatic xfer(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        mi = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                halfp();
                mi   = {mi[30:0], miso};
                sclk = ~cpol;
                halfp();
                sclk = cpol;
            end else begin
                halfp();
                sclk = ~cpol;
                mosi = mo[i];
                halfp();
                mi   = {mi[30:0], miso};
                sclk = cpol;
            end
        end
    endtask

    task automatic frame(input logic [31:0] mo, output logic [31:0] mi);
        cs = 1'b0;
        halfp();
        check("busy_in_frame", 32'(busy), 32'd1);
        xfer(mo, 32, mi);
        halfp();
        cs = 1'b1;
        idle_cycles(10);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},      32'(miso),      32'd0);
        check({tag, "_rx_data"},   rx_data,        32'd0);
        check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
        check({tag, "_tx_ready"},  32'(tx_ready),  32'd1);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        vec_t         vecs[4];
        logic [31:0]  mi, mi_a, mi_b, exp_m;
        int           pv, pf;

        vecs[0] = '{1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678};
        vecs[1] = '{1'b0, 1'b1, 32'hA5A5A5A5, 32'h0000CDEF, 32'h0000CDEF, 32'hA5A5A5A5};
        vecs[2] = '{1'b1, 1'b0, 32'hA5A5A5A5, 32'h0000CDEF, 32'h0000CDEF, 32'hA5A5A5A5};
        vecs[3] = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h0000CDEF, 32'h0000CDEF, 32'hA5A5A5A5};

        // Reset state
        idle_cycles(4);
        check_reset_values("rst");
        rstn = 1'b1;
        idle_cycles(4);
        check_reset_values("post_rst");

        // All four modes, one preloaded word each
        for (int v = 0; v < 4; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha);
            load(vecs[v].tx_word);
            check("tx_ready_after_load", 32'(tx_ready), 32'd0);
            pv = n_valid;
            sb.push_back(vecs[v].exp_rx);
            frame(vecs[v].mosi_word, mi);
            check("miso_word", mi, vecs[v].exp_miso);
            check("tx_ready_after_frame", 32'(tx_ready), 32'd1);
            check("rx_valid_count", 32'(n_valid - pv), 32'd1);
            last_rx = vecs[v].exp_rx;
        end

        // Underrun: zero, or the last received word in the echo build
        set_mode(1'b0, 1'b0);
`ifdef SPI_SLAVE_ECHO_EN
        exp_m = last_rx;
`else
        exp_m = 32'h0;
`endif
        sb.push_back(32'hDEADBEEF);
        frame(32'hDEADBEEF, mi);
        check("underrun_first", mi, exp_m);
        last_rx = 32'hDEADBEEF;
`ifdef SPI_SLAVE_ECHO_EN
        exp_m = last_rx;
`else
        exp_m = 32'h0;
`endif
        sb.push_back(32'h00000067);
        frame(32'h00000067, mi);
        check("underrun_second", mi, exp_m);
        last_rx = 32'h00000067;

        // Abort after 10 bits
        pv = n_valid;
        pf = n_ferr;
        cs = 1'b0;
        halfp();
        xfer(32'h000002AB, 10, mi);
        halfp();
        cs = 1'b1;
        idle_cycles(10);
        check("abort_frame_err", 32'(n_ferr - pf), 32'd1);
        check("abort_no_rx_valid", 32'(n_valid - pv), 32'd0);
        check("abort_rx_data", rx_data, last_rx);
        check("abort_busy", 32'(busy), 32'd0);

        // Back-to-back words with a mid-word load
        load(32'h0BADC0DE);
        pv = n_valid;
        sb.push_back(32'h11111111);
        sb.push_back(32'h22222222);
        cs = 1'b0;
        halfp();
        xfer(32'h00001111, 16, mi_a);
        check("b2b_tx_ready_mid", 32'(tx_ready), 32'd1);
        load(32'hCAFEF00D);
        check("b2b_tx_ready_loaded", 32'(tx_ready), 32'd0);
        xfer(32'h00001111, 16, mi_b);
        xfer(32'h22222222, 32, mi);
        halfp();
        cs = 1'b1;
        idle_cycles(10);
        check("b2b_miso_word1", {mi_a[15:0], mi_b[15:0]}, 32'h0BADC0DE);
        check("b2b_miso_word2", mi, 32'hCAFEF00D);
        check("b2b_rx_valid_count", 32'(n_valid - pv), 32'd2);
        last_rx = 32'h22222222;

        // Reset mid-frame with cs held low
        pv = n_valid;
        cs = 1'b0;
        halfp();
        xfer(32'h0000AAAA, 16, mi);
        rstn = 1'b0;
        idle_cycles(3);
        check_reset_values("midrst");
        rstn = 1'b1;
        idle_cycles(3);
        xfer(32'h000000FF, 8, mi);
        check("midrst_busy_ignored", 32'(busy), 32'd0);
        check("midrst_miso_ignored", mi, 32'h0);
        check("midrst_no_rx_valid", 32'(n_valid - pv), 32'd0);
        cs = 1'b1;
        idle_cycles(10);
        sb.push_back(32'h00000067);
        frame(32'h00000067, mi);
        check("midrst_miso_underrun", mi, 32'h0);
        check("midrst_rx_data", rx_data, 32'h00000067);
        last_rx = 32'h00000067;

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_sync.md
# spi_slave_sync

Synthesizable SPI slave that terminates the link driven by `spi_master`. All SPI pins are oversampled in the `sys_clk` domain, and the block supports all four CPOL/CPHA modes. Each frame shifts one `DATA_WIDTH`-bit word in on MOSI while a preloaded word shifts out on MISO. The block gives on-chip logic a parallel TX load handshake and an RX valid pulse.

## Interface
- `DATA_WIDTH`, 32, word length in bits (≥2).
- `sys_clk`  in  1  system clock; all logic is on its rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cpol`  in  1  clock polarity; static while `cs`=1 is sampled.
- `cpha`  in  1  clock phase; static while `cs`=1 is sampled.
- `cs`  in  1  chip select, active-low, asynchronous to `sys_clk`.
- `sclk`  in  1  SPI clock, asynchronous.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master, MSB first.
- `tx_data`  in  DATA_WIDTH  word for the next frame.
- `tx_load`  in  1  load strobe; accepted only when `tx_ready`=1.
- `tx_ready`  out  1  TX holding register empty.
- `rx_data`  out  DATA_WIDTH  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1  one-cycle pulse when `cs` rises mid-word.
- `busy`  out  1  high in ACTIVE.

## Operation
- **Synchronizers.** `cs`, `sclk` and `mosi` each pass through 2-flop synchronizers. A third register supplies edge detection.
- **Edge classes.**
  - Leading edge: `sclk` leaves the `cpol` level.
  - Trailing edge: `sclk` returns to the `cpol` level.
  - Sample edge: leading when `cpha`=0, trailing when `cpha`=1.
  - Drive edge: the other one.
- **Sampling.** On a sample edge, `rx_shift` = {`rx_shift`[W-2:0], `mosi_s`} and `bit_cnt` increments.
- **Driving.** On a drive edge, `tx_shift` shifts left by 1, but only when `bit_cnt`≠0. This means no shift on the first leading edge in CPHA=1. `miso` = `tx_shift`[W-1] at all times in ACTIVE, and 0 in IDLE.
- **TX holding register.**
  - `tx_load`&`tx_ready` copies `tx_data` into the holding register and clears `tx_ready`.
  - `tx_load` while `tx_ready`=0 is ignored.
  - At each word start the holding register moves into `tx_shift` and `tx_ready` sets.
  - If the holding register is empty at word start (underrun), `tx_shift` loads 0.
- **FSM.**
  - IDLE → ACTIVE on a `cs` falling edge (synchronized). The word-start load happens that cycle and `bit_cnt`=0.
  - ACTIVE, when `bit_cnt` reaches DATA_WIDTH on a sample edge:
    - `rx_data` takes the full word, including the current `mosi_s` bit.
    - `rx_valid` pulses.
    - `bit_cnt` returns to 0.
    - A word-start load happens, so continuous back-to-back words are supported.
  - ACTIVE → IDLE on a `cs` rising edge. If `bit_cnt`≠0, `frame_err` pulses, the partial word is discarded and there is no `rx_valid`.
- **Reset.** Asynchronous reset clears everything and forces IDLE. If `cs` is low at reset release, it is ignored until it goes high and then falls again.
- **Counter width.** `bit_cnt` is $clog2(DATA_WIDTH)+1 bits wide.

## Timing
- **Reset values:** `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `frame_err`=0, `busy`=0.
- **Pin-to-action latency:** 3 `sys_clk` cycles from any pin transition to the registered action.
- **`sclk` limit:** each `sclk` half-period is ≥4 `sys_clk` cycles.
- **CS setup:** the master allows ≥4 `sys_clk` cycles from `cs` fall to the first `sclk` edge. In CPHA=0 the MSB is on `miso` 3 cycles after `cs` falls.
- **MISO update:** `miso` changes 3–4 `sys_clk` cycles after the drive edge at the pin, so it is stable before the next sample edge.
- **`rx_valid`:** asserted the cycle after the last sample edge is detected.
- **`tx_ready`:** rises the cycle after a word start. `tx_data` loaded before the final sample edge of the current word is used for the next word.
- **Same-cycle word start and `tx_load`:** the holding content moves first and `tx_ready` stays 1. The new load is not accepted that cycle.

## Configuration
- **`SPI_SLAVE_ECHO_EN` defined:** on underrun, `tx_shift` loads the current `rx_data`, i.e. the last received word. This gives a loopback for master self-test.
- **`SPI_SLAVE_ECHO_EN` undefined:** underrun loads 0.
- All other behaviour is identical in both builds.

## Test plan
- **Mode 0, 32-bit word.** `tx_load` 0x12345678; master sends 0xDEADBEEF → `rx_valid` once, `rx_data`=0xDEADBEEF, master receives 0x12345678, `tx_ready`=1 afterwards.
- **Modes 1, 2, 3 in turn.** Master sends 0x0000CDEF with `tx_data`=0xA5A5A5A5 → each mode gives `rx_data`=0x0000CDEF and master receives 0xA5A5A5A5.
- **Echo, `SPI_SLAVE_ECHO_EN` defined.** No `tx_load`, frames 0xDEADBEEF then 0x00000067 → second MISO word is 0xDEADBEEF. Without the macro it is 0x00000000.
- **Abort.** `cs` rises after 10 bits → `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, `busy`=0.
- **Back-to-back.** `cs` held low for 64 bits, 0x11111111 then 0x22222222, with 0xCAFEF00D loaded during word 1 → two `rx_valid` pulses, and MISO word 2 is 0xCAFEF00D.
- **Reset mid-frame.** `rstn`=0 at bit 16 with `cs` still low → all outputs at reset values. No activity until `cs` goes high and falls again, after which a 0x00000067 frame is received correctly.
